// File: rtl/bcd_sevenseg_scanner.sv
// Purpose: scan three latched BCD digits onto a multiplexed common-anode 7-segment display.
// Latency: new digits appear at the first frame after the boundary that follows the load.
// Backpressure: none; load is accepted every cycle and only the newest digits are kept.
module bcd_sevenseg_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit AN_ACT_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       load,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] an,
  output logic       frame_done
);

  localparam int MAXC_A = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int MAXC   = (MAXC_A > 2) ? MAXC_A : 2;
  localparam int CW     = $clog2(MAXC);

  localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_t;

  // With no blank gap the scanner never visits BLANK at all.
  localparam phase_t PH_RST = (BLANK_CYCLES == 0) ? PH_ON : PH_BLANK;

  phase_t        phase_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic [11:0]   shadow_q;
  logic [11:0]   disp_q;
  logic          pending_q;

  logic          on_last;
  logic          boundary;

  assign on_last  = (phase_q == PH_ON) && (cnt_q == ON_LAST);
  assign boundary = on_last && (idx_q == 2'd2);

  // Slot sequencer: BLANK gap, then ON for one digit, then move to the next digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_RST;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      case (phase_q)
        PH_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            phase_q <= PH_ON;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == ON_LAST) begin
            phase_q <= PH_RST;
            cnt_q   <= '0;
            idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Digit capture: loads land in the shadow and are committed to the display only at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      if (load) begin
        shadow_q  <= {hundreds, tens, ones};
        pending_q <= 1'b1;
      end
      if (boundary) begin
        if (load) begin
          disp_q <= {hundreds, tens, ones};
        end else if (pending_q) begin
          disp_q <= shadow_q;
        end
        pending_q <= 1'b0;
      end
    end
  end

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'h3F;
      4'd1:    seg_pattern = 7'h06;
      4'd2:    seg_pattern = 7'h5B;
      4'd3:    seg_pattern = 7'h4F;
      4'd4:    seg_pattern = 7'h66;
      4'd5:    seg_pattern = 7'h6D;
      4'd6:    seg_pattern = 7'h7D;
      4'd7:    seg_pattern = 7'h07;
      4'd8:    seg_pattern = 7'h7F;
      4'd9:    seg_pattern = 7'h6F;
      default: seg_pattern = 7'h40;
    endcase
  endfunction

  logic [3:0] cur_digit;
  logic       blank_digit;
  logic [6:0] seg_act;
  logic [2:0] an_act;

  // Output decode from registered state only: pick the slot digit, apply leading-zero blanking and polarity.
  always_comb begin
    cur_digit   = disp_q[3:0];
    blank_digit = 1'b0;
    case (idx_q)
      2'd0: begin
        cur_digit   = disp_q[3:0];
        blank_digit = 1'b0;
      end
      2'd1: begin
        cur_digit   = disp_q[7:4];
        blank_digit = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
      end
      default: begin
        cur_digit   = disp_q[11:8];
        blank_digit = (disp_q[11:8] == 4'd0);
      end
    endcase
    seg_act    = ((phase_q == PH_ON) && !blank_digit) ? seg_pattern(cur_digit) : 7'h00;
    an_act     = (phase_q == PH_ON) ? (3'b001 << idx_q) : 3'b000;
    seg        = SEG_ACT_LOW ? ~seg_act : seg_act;
    an         = AN_ACT_LOW ? ~an_act : an_act;
    dp         = SEG_ACT_LOW;
    frame_done = boundary;
  end

endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
// Bench for bcd_sevenseg_scanner with REFRESH_DIV=4, BLANK_CYCLES=1, active-low outputs.
// A time-based display model predicts every output each cycle; literal checks pin key frames.
// Random loads and occasional resets exercise the frame-boundary commit rules.
module tb_bcd_sevenseg_scanner;

  localparam int RD    = 4;
  localparam int BC    = 1;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = 3 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hundreds = '0;
  logic [3:0] tens = '0;
  logic [3:0] ones = '0;
  logic       load = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] an;
  logic       frame_done;

  int checks = 0;
  int failures = 0;

  bcd_sevenseg_scanner #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .SEG_ACT_LOW (1'b1),
    .AN_ACT_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .load      (load),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model state: cycles since reset, displayed digits [0]=ones..[2]=hundreds, shadow, pending.
  int         t = 0;
  bit         mvalid = 1'b0;
  logic [3:0] md[3];
  logic [3:0] ms[3];
  bit         mpend = 1'b0;
  logic [6:0] tbl[16];

  initial begin
    tbl[0] = 7'h3F; tbl[1] = 7'h06; tbl[2] = 7'h5B; tbl[3] = 7'h4F;
    tbl[4] = 7'h66; tbl[5] = 7'h6D; tbl[6] = 7'h7D; tbl[7] = 7'h07;
    tbl[8] = 7'h7F; tbl[9] = 7'h6F;
    for (int i = 10; i < 16; i++) tbl[i] = 7'h40;
    for (int i = 0; i < 3; i++) begin
      md[i] = '0;
      ms[i] = '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // Model advance on each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      mpend = 1'b0;
      for (int i = 0; i < 3; i++) begin
        md[i] = '0;
        ms[i] = '0;
      end
      mvalid = 1'b1;
    end else begin
      if (load) begin
        ms[0] = ones; ms[1] = tens; ms[2] = hundreds;
        mpend = 1'b1;
      end
      if ((t % FRAME) == FRAME - 1) begin
        if (load) begin
          md[0] = ones; md[1] = tens; md[2] = hundreds;
        end else if (mpend) begin
          md = ms;
        end
        mpend = 1'b0;
      end
      t = t + 1;
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (mvalid) begin
      int pos, slot;
      bit on, blank;
      logic [2:0] e_an;
      logic [6:0] e_seg;
      pos   = t % FRAME;
      slot  = pos / SLOT;
      on    = (pos % SLOT) >= BC;
      blank = (slot == 2) ? (md[2] == 0) :
              (slot == 1) ? (md[2] == 0 && md[1] == 0) : 1'b0;
      e_an  = on ? ~(3'b001 << slot) : 3'b111;
      e_seg = (on && !blank) ? ~tbl[md[slot]] : 7'h7F;
      chk("model_an", an, e_an);
      chk("model_seg", seg, e_seg);
      chk("model_dp", dp, 1'b1);
      chk("model_frame_done", frame_done, (pos == FRAME - 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] tn, input logic [3:0] o);
    hundreds = h; tens = tn; ones = o; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while ((t % FRAME) != p && n < 2 * FRAME) begin
      tick();
      n++;
    end
    checks++;
    if ((t % FRAME) != p) begin
      failures++;
      $display("FAIL wait_pos timeout actual=%0d required=%0d", t % FRAME, p);
    end
  endtask

  task automatic next_frame_pos(input int p);
    wait_pos(FRAME - 1);
    tick();
    wait_pos(p);
  endtask

  task automatic lit(input string name, input logic [2:0] e_an, input logic [6:0] e_seg);
    chk({name, "_an"}, an, e_an);
    chk({name, "_seg"}, seg, e_seg);
  endtask

  initial begin
    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) tick();
    lit("reset", 3'b111, 7'h7F);
    chk("reset_dp", dp, 1'b1);
    chk("reset_fd", frame_done, 1'b0);
    rst = 1'b0;
    chk("rel_c0_an", an, 3'b111);
    tick();
    chk("rel_c1_an", an, 3'b110);

    // 128
    do_load(4'd1, 4'd2, 4'd8);
    next_frame_pos(1);
    lit("l128_ones", 3'b110, 7'h00);
    wait_pos(6);
    lit("l128_tens", 3'b101, 7'h24);
    wait_pos(11);
    lit("l128_hund", 3'b011, 7'h79);
    wait_pos(13);
    chk("fd_pos13", frame_done, 1'b0);
    wait_pos(14);
    chk("fd_pos14", frame_done, 1'b1);

    // 007 -> "  7"
    do_load(4'd0, 4'd0, 4'd7);
    next_frame_pos(1);
    lit("l007_ones", 3'b110, 7'h78);
    wait_pos(6);
    lit("l007_tens", 3'b101, 7'h7F);
    wait_pos(11);
    lit("l007_hund", 3'b011, 7'h7F);

    // 000 -> "  0"
    do_load(4'd0, 4'd0, 4'd0);
    next_frame_pos(1);
    lit("l000_ones", 3'b110, 7'h40);
    wait_pos(6);
    lit("l000_tens", 3'b101, 7'h7F);
    wait_pos(11);
    lit("l000_hund", 3'b011, 7'h7F);

    // 0,10,5 -> " -5"
    do_load(4'd0, 4'd10, 4'd5);
    next_frame_pos(1);
    lit("l0a5_ones", 3'b110, 7'h12);
    wait_pos(6);
    lit("l0a5_tens", 3'b101, 7'h3F);
    wait_pos(11);
    lit("l0a5_hund", 3'b011, 7'h7F);

    // Mid-frame loads do not disturb the current frame; last one wins next frame.
    wait_pos(3);
    do_load(4'd2, 4'd5, 4'd5);
    tick();
    do_load(4'd1, 4'd1, 4'd1);
    lit("midload_tens", 3'b101, 7'h3F);
    wait_pos(11);
    lit("midload_hund", 3'b011, 7'h7F);
    next_frame_pos(1);
    lit("l111_ones", 3'b110, 7'h79);
    wait_pos(6);
    lit("l111_tens", 3'b101, 7'h79);
    wait_pos(11);
    lit("l111_hund", 3'b011, 7'h79);

    // Load on the boundary cycle takes effect immediately in the next frame.
    wait_pos(14);
    do_load(4'd3, 4'd3, 4'd3);
    wait_pos(1);
    lit("l333_ones", 3'b110, 7'h30);
    wait_pos(11);
    lit("l333_hund", 3'b011, 7'h30);

    // Reset during tens ON with a pending load discards it.
    wait_pos(7);
    do_load(4'd9, 4'd9, 4'd9);
    rst = 1'b1;
    tick();
    lit("midrst", 3'b111, 7'h7F);
    chk("midrst_fd", frame_done, 1'b0);
    rst = 1'b0;
    wait_pos(1);
    lit("postrst_ones", 3'b110, 7'h40);
    wait_pos(6);
    lit("postrst_tens", 3'b101, 7'h7F);
    next_frame_pos(1);
    lit("postrst2_ones", 3'b110, 7'h40);
    wait_pos(11);
    lit("postrst2_hund", 3'b011, 7'h7F);

    // Random loads, digits 0..15, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      hundreds = 4'($urandom_range(0, 15));
      tens     = 4'($urandom_range(0, 15));
      ones     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) hundreds = 4'd0;
      if ($urandom_range(0, 3) == 0) tens = 4'd0;
      load = ($urandom_range(0, 6) == 0);
      rst  = ($urandom_range(0, 250) == 0);
      tick();
    end
    load = 1'b0;
    rst  = 1'b0;
    repeat (2 * FRAME) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
